traffic_monitor: RTL and testbench

TRAFFIC_MONITOR -- requirements
Module: traffic_monitor

---
 rtl/traffic_monitor_if.sv | 24 ++
 rtl/traffic_monitor.sv | 160 ++++++++++++++++
 tb/tb_traffic_monitor.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_monitor_if.sv
// Lamp samples into the monitor and latched fault / phase status out of it.
interface traffic_monitor_if;
    logic [2:0] w_to_e;
    logic [2:0] w_to_n;
    logic [2:0] e_to_w;
    logic [2:0] e_to_n;
    logic [2:0] n_to_e;
    logic [2:0] n_to_w;
    logic       fault_clr;
    logic       fault;
    logic [2:0] fault_code;
    logic [2:0] fault_light;
    logic [1:0] phase_id;

    modport master (
        output w_to_e, w_to_n, e_to_w, e_to_n, n_to_e, n_to_w, fault_clr,
        input  fault, fault_code, fault_light, phase_id
    );

    modport slave (
        input  w_to_e, w_to_n, e_to_w, e_to_n, n_to_e, n_to_w, fault_clr,
        output fault, fault_code, fault_light, phase_id
    );
endinterface

// File: rtl/traffic_monitor.sv
// Checks six sampled traffic lamps for bad encodings, illegal steps, short
// dwell and conflicting greens; latches the first fault until cleared.
module traffic_monitor #(
    parameter logic [26:0] MIN_DWELL = 27'd100_000_000
) (
    input logic clk,
    input logic rst,
    traffic_monitor_if.slave bus
);
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] RED_YL = 3'b110;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;

    localparam logic [2:0] F_ENC = 3'b001;
    localparam logic [2:0] F_TRN = 3'b010;
    localparam logic [2:0] F_CNF = 3'b011;
    localparam logic [2:0] F_DWL = 3'b100;

    // Light bitmaps of the three permitted phases (bit i = light index i).
    localparam logic [5:0] P1_MASK = 6'b001101;
    localparam logic [5:0] P2_MASK = 6'b100011;
    localparam logic [5:0] P3_MASK = 6'b111000;

    logic [2:0]  code [6];
    logic [2:0]  prev [6];
    logic [26:0] hold [6];

    logic [5:0] enc_bad, trn_bad, dwl_bad, nonred;
    logic       fit1, fit2, fit3, conflict;
    logic [1:0] phase_nxt;
    logic       det;
    logic [2:0] det_code, det_light;

    logic       fault_q;
    logic [2:0] code_q, light_q;
    logic [1:0] phase_q;

    assign code[0] = bus.w_to_e;
    assign code[1] = bus.w_to_n;
    assign code[2] = bus.e_to_w;
    assign code[3] = bus.e_to_n;
    assign code[4] = bus.n_to_e;
    assign code[5] = bus.n_to_w;

    function automatic logic is_legal(input logic [2:0] c);
        return (c == RED) || (c == RED_YL) || (c == GREEN) || (c == YELLOW);
    endfunction

    function automatic logic step_ok(input logic [2:0] p, input logic [2:0] c);
        logic ok;
        ok = (c == p);
        case (p)
            RED:     ok = ok || (c == RED_YL);
            RED_YL:  ok = ok || (c == GREEN);
            GREEN:   ok = ok || (c == YELLOW);
            YELLOW:  ok = ok || (c == RED);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] first_idx(input logic [5:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_comb begin
        enc_bad = '0;
        trn_bad = '0;
        dwl_bad = '0;
        nonred  = '0;
        for (int i = 0; i < 6; i++) begin
            enc_bad[i] = !is_legal(code[i]);
            nonred[i]  = (code[i] != RED);
            // A garbled code on either side makes the step meaningless.
            if (is_legal(code[i]) && is_legal(prev[i])) begin
                trn_bad[i] = !step_ok(prev[i], code[i]);
                dwl_bad[i] = (code[i] != prev[i]) && (prev[i] != RED) &&
                             (hold[i] < MIN_DWELL);
            end
        end
    end

    always_comb begin
        fit1     = ((nonred & ~P1_MASK) == 6'b0);
        fit2     = ((nonred & ~P2_MASK) == 6'b0);
        fit3     = ((nonred & ~P3_MASK) == 6'b0);
        conflict = !(fit1 || fit2 || fit3);
        phase_nxt = 2'd0;
        if (nonred != 6'b0) begin
            if (fit1)      phase_nxt = 2'd1;
            else if (fit2) phase_nxt = 2'd2;
            else if (fit3) phase_nxt = 2'd3;
        end
    end

    always_comb begin
        det       = 1'b1;
        det_code  = 3'b000;
        det_light = 3'b000;
        if (enc_bad != 6'b0) begin
            det_code  = F_ENC;
            det_light = first_idx(enc_bad);
        end else if (conflict) begin
            det_code  = F_CNF;
            det_light = 3'b111;
        end else if (trn_bad != 6'b0) begin
            det_code  = F_TRN;
            det_light = first_idx(trn_bad);
        end else if (dwl_bad != 6'b0) begin
            det_code  = F_DWL;
            det_light = first_idx(dwl_bad);
        end else begin
            det = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                prev[i] <= RED;
                hold[i] <= '0;
            end
            fault_q <= 1'b0;
            code_q  <= 3'b000;
            light_q <= 3'b000;
            phase_q <= 2'b00;
        end else begin
            for (int i = 0; i < 6; i++) begin
                prev[i] <= code[i];
                if (code[i] == prev[i]) begin
                    if (hold[i] < MIN_DWELL) hold[i] <= hold[i] + 27'd1;
                end else begin
                    hold[i] <= 27'd1;
                end
            end
            phase_q <= phase_nxt;
            // A clear in the same cycle as a new fault yields the new fault.
            if (det && (!fault_q || bus.fault_clr)) begin
                fault_q <= 1'b1;
                code_q  <= det_code;
                light_q <= det_light;
            end else if (bus.fault_clr) begin
                fault_q <= 1'b0;
                code_q  <= 3'b000;
                light_q <= 3'b000;
            end
        end
    end

    assign bus.fault       = fault_q;
    assign bus.fault_code  = code_q;
    assign bus.fault_light = light_q;
    assign bus.phase_id    = phase_q;
endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor: a rule-level model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_traffic_monitor;
    localparam int MD = 4;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] A = 3'b110;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] X = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic [2:0] lamps [6];

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    logic [2:0] mprev [6];
    int         run [6];
    logic       exp_fault;
    logic [2:0] exp_code, exp_light;
    logic [1:0] exp_phase;

    // Lights belonging to phases 1, 2, 3.
    int pset [3][3] = '{'{0, 2, 3}, '{0, 1, 5}, '{4, 5, 3}};

    traffic_monitor_if bus ();

    assign bus.w_to_e    = lamps[0];
    assign bus.w_to_n    = lamps[1];
    assign bus.e_to_w    = lamps[2];
    assign bus.e_to_n    = lamps[3];
    assign bus.n_to_e    = lamps[4];
    assign bus.n_to_w    = lamps[5];
    assign bus.fault_clr = clr;

    traffic_monitor #(.MIN_DWELL(27'(MD))) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit legal(input logic [2:0] c);
        return (c == R) || (c == A) || (c == G) || (c == Y);
    endfunction

    function automatic logic [2:0] succ(input logic [2:0] c);
        case (c)
            R: return A;
            A: return G;
            G: return Y;
            Y: return R;
            default: return c;
        endcase
    endfunction

    function automatic bit in_set(input int p, input int light);
        for (int k = 0; k < 3; k++) if (pset[p][k] == light) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin : model
        bit found, conflict, any_nr, fits;
        logic [2:0] fc, fl;
        logic [1:0] ph;
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                mprev[i] = R;
                run[i]   = 0;
            end
            exp_fault = 1'b0; exp_code = 3'd0; exp_light = 3'd0; exp_phase = 2'd0;
        end else begin
            any_nr = 1'b0;
            for (int i = 0; i < 6; i++) if (lamps[i] != R) any_nr = 1'b1;
            ph = 2'd0;
            conflict = 1'b1;
            for (int p = 0; p < 3; p++) begin
                fits = 1'b1;
                for (int i = 0; i < 6; i++)
                    if (lamps[i] != R && !in_set(p, i)) fits = 1'b0;
                if (fits) begin
                    conflict = 1'b0;
                    if (ph == 2'd0) ph = 2'(p + 1);
                end
            end
            if (!any_nr) ph = 2'd0;

            found = 1'b0; fc = 3'd0; fl = 3'd0;
            for (int i = 0; i < 6; i++)
                if (!found && !legal(lamps[i])) begin found = 1; fc = 3'b001; fl = 3'(i); end
            if (!found && conflict) begin found = 1; fc = 3'b011; fl = 3'b111; end
            for (int i = 0; i < 6; i++)
                if (!found && legal(lamps[i]) && legal(mprev[i]) &&
                    lamps[i] != mprev[i] && lamps[i] != succ(mprev[i])) begin
                    found = 1; fc = 3'b010; fl = 3'(i);
                end
            for (int i = 0; i < 6; i++)
                if (!found && legal(lamps[i]) && legal(mprev[i]) && lamps[i] != mprev[i] &&
                    mprev[i] != R && run[i] < MD) begin
                    found = 1; fc = 3'b100; fl = 3'(i);
                end

            if (found && (!exp_fault || clr)) begin
                exp_fault = 1'b1; exp_code = fc; exp_light = fl;
            end else if (clr) begin
                exp_fault = 1'b0; exp_code = 3'd0; exp_light = 3'd0;
            end
            exp_phase = ph;

            for (int i = 0; i < 6; i++) begin
                run[i]   = (lamps[i] == mprev[i]) ? run[i] + 1 : 1;
                mprev[i] = lamps[i];
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_fault", 8'(bus.fault), 8'(exp_fault));
            check("model_code", 8'(bus.fault_code), 8'(exp_code));
            check("model_light", 8'(bus.fault_light), 8'(exp_light));
            check("model_phase", 8'(bus.phase_id), 8'(exp_phase));
        end
    end

    task automatic cyc(input int n, input logic [2:0] c0, c1, c2, c3, c4, c5,
                       input logic cl);
        lamps[0] = c0; lamps[1] = c1; lamps[2] = c2;
        lamps[3] = c3; lamps[4] = c4; lamps[5] = c5;
        clr = cl;
        repeat (n) @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic lit(input string nm, input logic f, input logic [2:0] c,
                       input logic [2:0] l, input logic [1:0] p);
        check({nm, "_fault"}, 8'(bus.fault), 8'(f));
        check({nm, "_code"}, 8'(bus.fault_code), 8'(c));
        check({nm, "_light"}, 8'(bus.fault_light), 8'(l));
        check({nm, "_phase"}, 8'(bus.phase_id), 8'(p));
    endtask

    initial begin
        for (int i = 0; i < 6; i++) lamps[i] = R;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        lit("reset", 1'b0, 3'd0, 3'd0, 2'd0);
        rst = 1'b0;

        // Full legal rotation through all three phases.
        cyc(4, A, R, A, A, R, R, 0);
        cyc(4, G, R, G, G, R, R, 0);
        lit("p1_green", 1'b0, 3'd0, 3'd0, 2'd1);
        cyc(4, Y, R, Y, Y, R, R, 0);
        cyc(4, R, R, R, R, R, R, 0);
        cyc(4, A, A, R, R, R, A, 0);
        cyc(4, G, G, R, R, R, G, 0);
        lit("p2_green", 1'b0, 3'd0, 3'd0, 2'd2);
        cyc(4, Y, Y, R, R, R, Y, 0);
        cyc(4, R, R, R, R, R, R, 0);
        cyc(4, R, R, R, A, A, A, 0);
        cyc(4, R, R, R, G, G, G, 0);
        lit("p3_green", 1'b0, 3'd0, 3'd0, 2'd3);
        cyc(4, R, R, R, Y, Y, Y, 0);
        cyc(4, R, R, R, R, R, R, 0);
        lit("cycle_end", 1'b0, 3'd0, 3'd0, 2'd0);

        // Green held one cycle short.
        cyc(4, A, R, R, R, R, R, 0);
        cyc(3, G, R, R, R, R, R, 0);
        cyc(1, Y, R, R, R, R, R, 0);
        lit("dwell", 1'b1, 3'b100, 3'b000, 2'd1);
        cyc(4, Y, R, R, R, R, R, 0);
        cyc(2, R, R, R, R, R, R, 0);
        lit("dwell_held", 1'b1, 3'b100, 3'b000, 2'd0);
        cyc(1, R, R, R, R, R, R, 1);
        lit("clr_legal", 1'b0, 3'd0, 3'd0, 2'd0);

        // Conflicting greens.
        cyc(1, G, R, R, R, G, R, 0);
        lit("conflict", 1'b1, 3'b011, 3'b111, 2'd0);
        cyc(1, R, R, R, R, R, R, 0);
        cyc(1, R, R, R, R, R, R, 1);
        lit("clr2", 1'b0, 3'd0, 3'd0, 2'd0);

        // Encoding beats a simultaneous transition fault.
        cyc(4, R, R, A, R, R, R, 0);
        cyc(4, R, R, G, R, R, R, 0);
        cyc(1, R, R, R, R, R, X, 0);
        lit("encoding", 1'b1, 3'b001, 3'b101, 2'd2);

        // Clear collides with a new RED->GREEN fault.
        cyc(1, R, R, R, R, R, R, 0);
        cyc(1, R, G, R, R, R, R, 1);
        lit("clr_vs_new", 1'b1, 3'b010, 3'b001, 2'd2);
        cyc(1, R, R, R, R, R, R, 0);
        cyc(1, R, R, R, R, R, R, 1);
        lit("clr3", 1'b0, 3'd0, 3'd0, 2'd0);

        // Reset while a fault is latched during P2 green.
        cyc(4, A, A, R, R, R, A, 0);
        cyc(4, G, G, R, R, R, G, 0);
        cyc(1, G, G, R, R, A, G, 0);
        lit("p2_conflict", 1'b1, 3'b011, 3'b111, 2'd0);
        rst = 1'b1;
        cyc(1, G, G, R, R, R, G, 0);
        rst = 1'b0;
        lit("mid_reset", 1'b0, 3'd0, 3'd0, 2'd0);
        cyc(1, A, A, R, R, R, A, 0);
        lit("after_reset", 1'b0, 3'd0, 3'd0, 2'd2);

        // Red-yellow cut short.
        cyc(1, A, A, R, R, R, A, 0);
        cyc(1, G, G, R, R, R, G, 0);
        lit("ry_short", 1'b1, 3'b100, 3'b000, 2'd2);
        cyc(3, G, G, R, R, R, G, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
